// File: rtl/mram_pg_pkg.sv
// mram_pg_pkg
// Shared definitions for the MRAM power-gating sequencer:
//   - DEFAULT_CNT_WIDTH : default width of the per-rail settle counter
//   - VDD/VDDA/VREF     : bit positions of each rail in the rail vector
//   - pg_state_e        : 3-bit sequencer state encoding (also driven on state_o)
package mram_pg_pkg;

  localparam int DEFAULT_CNT_WIDTH = 8;

  localparam int VDD  = 0;
  localparam int VDDA = 1;
  localparam int VREF = 2;

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    UP_VDD  = 3'd1,
    UP_VDDA = 3'd2,
    UP_VREF = 3'd3,
    ON      = 3'd4,
    DN_VREF = 3'd5,
    DN_VDDA = 3'd6,
    DN_VDD  = 3'd7
  } pg_state_e;

endpackage

// File: rtl/mram_pg_sequencer_dly.sv
// pg_dly_counter
// Loadable settle-delay down-counter used for every rail dwell.
// Ports:
//   clk          : clock
//   rst_n        : synchronous active-low reset, clears the count
//   en           : counting enabled (sequencer is in an UP/DN state)
//   load         : load load_val this edge (wins over freeze)
//   load_val     : settle cycles for the next dwell
//   freeze       : hold the count and suppress natural expiry
//   force_expire : report expiry immediately, regardless of the count
//   expired      : current dwell is over, the sequencer may advance
module pg_dly_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 freeze,
  input  logic                 force_expire,
  output logic                 expired
);

  logic [CNT_WIDTH-1:0] count;

  // Load has priority so a forced step while frozen still arms the next
  // dwell. The count parks at zero so expiry keeps being reported until
  // the sequencer loads a new value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !freeze && (count != '0)) begin
      count <= count - CNT_WIDTH'(1);
    end
  end

  // Zero count means the last settle cycle is in progress, giving a dwell
  // of load_val+1 cycles.
  assign expired = en & (force_expire | (~freeze & (count == '0)));

endmodule

// File: rtl/mram_pg_sequencer.sv
// mram_pg_sequencer
// Sequences the three MRAM supply rails on in the order VDD, VDDA, VREF and
// off in the reverse order, dwelling a programmable number of cycles per rail.
// Ports:
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   pwr_req_i              : level request, 1 = MRAM should be powered
//   cfg_dly_{vdd,vdda,vref}_i : settle cycles per rail (sampled at load)
//   ext_force_off_i        : forces power-down regardless of pwr_req_i
//   hold_i, step_i         : freeze sequencing / single-step while frozen
//   {vdd,vdda,vref}_pg_o   : registered rail enables
//   pwr_ack_o              : high only when fully powered (ON)
//   busy_o                 : high in any UP/DN state
//   state_o                : current state encoding
module mram_pg_sequencer
  import mram_pg_pkg::*;
#(
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 pwr_req_i,
  output logic                 pwr_ack_o,
  input  logic [CNT_WIDTH-1:0] cfg_dly_vdd_i,
  input  logic [CNT_WIDTH-1:0] cfg_dly_vdda_i,
  input  logic [CNT_WIDTH-1:0] cfg_dly_vref_i,
  input  logic                 ext_force_off_i,
  input  logic                 hold_i,
  input  logic                 step_i,
  output logic                 vdd_pg_o,
  output logic                 vdda_pg_o,
  output logic                 vref_pg_o,
  output logic                 busy_o,
  output logic [2:0]           state_o
);

  pg_state_e            state, state_next;
  logic [2:0]           rails, rails_next;
  logic                 step_q;
  logic                 step_edge;
  logic                 want;
  logic                 go;
  logic                 in_dwell;
  logic                 load;
  logic [CNT_WIDTH-1:0] load_val;
  logic                 expired;

  assign want      = pwr_req_i & ~ext_force_off_i;
  assign step_edge = step_i & ~step_q;
  // OFF/ON transitions are allowed freely when running, or once per step
  // edge while held.
  assign go        = ~hold_i | step_edge;
  assign in_dwell  = (state != OFF) && (state != ON);

  pg_dly_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_dly (
    .clk          (clk_i),
    .rst_n        (rst_ni),
    .en           (in_dwell),
    .load         (load),
    .load_val     (load_val),
    .freeze       (hold_i),
    .force_expire (hold_i & step_edge),
    .expired      (expired)
  );

  // Next-state logic. Each transition changes at most one rail, and an
  // aborted power-up turns around at the rail it just raised, so the rail
  // vector always stays a legal prefix of VDD, VDDA, VREF.
  always_comb begin
    state_next = state;
    rails_next = rails;
    load       = 1'b0;
    load_val   = '0;
    case (state)
      OFF: begin
        if (go && want) begin
          state_next      = UP_VDD;
          rails_next[VDD] = 1'b1;
          load            = 1'b1;
          load_val        = cfg_dly_vdd_i;
        end
      end
      UP_VDD: begin
        if (expired) begin
          load = 1'b1;
          if (want) begin
            state_next       = UP_VDDA;
            rails_next[VDDA] = 1'b1;
            load_val         = cfg_dly_vdda_i;
          end else begin
            state_next      = DN_VDD;
            rails_next[VDD] = 1'b0;
            load_val        = cfg_dly_vdd_i;
          end
        end
      end
      UP_VDDA: begin
        if (expired) begin
          load = 1'b1;
          if (want) begin
            state_next       = UP_VREF;
            rails_next[VREF] = 1'b1;
            load_val         = cfg_dly_vref_i;
          end else begin
            state_next       = DN_VDDA;
            rails_next[VDDA] = 1'b0;
            load_val         = cfg_dly_vdda_i;
          end
        end
      end
      UP_VREF: begin
        if (expired) begin
          if (want) begin
            state_next = ON;
          end else begin
            state_next       = DN_VREF;
            rails_next[VREF] = 1'b0;
            load             = 1'b1;
            load_val         = cfg_dly_vref_i;
          end
        end
      end
      ON: begin
        if (go && !want) begin
          state_next       = DN_VREF;
          rails_next[VREF] = 1'b0;
          load             = 1'b1;
          load_val         = cfg_dly_vref_i;
        end
      end
      DN_VREF: begin
        if (expired) begin
          state_next       = DN_VDDA;
          rails_next[VDDA] = 1'b0;
          load             = 1'b1;
          load_val         = cfg_dly_vdda_i;
        end
      end
      DN_VDDA: begin
        if (expired) begin
          state_next      = DN_VDD;
          rails_next[VDD] = 1'b0;
          load            = 1'b1;
          load_val        = cfg_dly_vdd_i;
        end
      end
      DN_VDD: begin
        if (expired) begin
          state_next = OFF;
        end
      end
      default: begin
        state_next = OFF;
        rails_next = '0;
      end
    endcase
  end

  // State, rail and step-history registers. Reset drops every rail at once;
  // no ordered power-down is attempted.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state  <= OFF;
      rails  <= '0;
      step_q <= 1'b0;
    end else begin
      state  <= state_next;
      rails  <= rails_next;
      step_q <= step_i;
    end
  end

  assign vdd_pg_o  = rails[VDD];
  assign vdda_pg_o = rails[VDDA];
  assign vref_pg_o = rails[VREF];
  assign pwr_ack_o = (state == ON);
  assign busy_o    = in_dwell;
  assign state_o   = state;

endmodule

// File: tb/tb_mram_pg_sequencer.sv
// tb_mram_pg_sequencer
// Self-checking bench for mram_pg_sequencer: a table of per-cycle vectors
// for the basic up/down sequence, hand-written sequences for abort, hold,
// step, forced-off and reset cases, then a randomized run watched by the
// rail-ordering and one-toggle-per-edge invariant checker.
module tb_mram_pg_sequencer;

  logic       clk;
  logic       rst_n;
  logic       pwr_req;
  logic       pwr_ack;
  logic [7:0] dly_vdd, dly_vdda, dly_vref;
  logic       force_off;
  logic       hold;
  logic       step;
  logic       vdd_pg, vdda_pg, vref_pg;
  logic       busy;
  logic [2:0] state;

  int check_cnt = 0;
  int pass_cnt  = 0;

  logic       inv_armed = 1'b0;
  logic       rst_at_edge = 1'b0;
  logic [2:0] prev_rails = 3'b000;

  mram_pg_sequencer #(.CNT_WIDTH(8)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .pwr_req_i       (pwr_req),
    .pwr_ack_o       (pwr_ack),
    .cfg_dly_vdd_i   (dly_vdd),
    .cfg_dly_vdda_i  (dly_vdda),
    .cfg_dly_vref_i  (dly_vref),
    .ext_force_off_i (force_off),
    .hold_i          (hold),
    .step_i          (step),
    .vdd_pg_o        (vdd_pg),
    .vdda_pg_o       (vdda_pg),
    .vref_pg_o       (vref_pg),
    .busy_o          (busy),
    .state_o         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n, req, force_off, hold, step;
    logic [7:0] dly;
    logic [2:0] rails;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(logic r, logic q, logic f, logic h, logic s,
                               logic [7:0] d, logic [2:0] rl, logic [2:0] st);
    vec_t v;
    v.rst_n = r; v.req = q; v.force_off = f; v.hold = h; v.step = s;
    v.dly = d; v.rails = rl; v.st = st;
    return v;
  endfunction

  // Expected output bundle {vdd, vdda, vref, ack, busy, state}; ack and busy
  // follow directly from the state encoding.
  function automatic logic [7:0] ev(logic [2:0] rl, logic [2:0] st);
    return {rl, st == 3'd4, (st != 3'd0) && (st != 3'd4), st};
  endfunction

  task automatic recordCheck(input bit ok, input string name,
                             input logic [7:0] actual, input logic [7:0] required);
    check_cnt++;
    if (ok) pass_cnt++;
    else $display("[TB] FAIL %s: got %b, expected %b", name, actual, required);
  endtask

  task automatic applyStimulus(input logic r, input logic q, input logic f,
                               input logic h, input logic s);
    rst_n = r; pwr_req = q; force_off = f; hold = h; step = s;
  endtask

  task automatic setDly(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    dly_vdd = a; dly_vdda = b; dly_vref = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input logic [7:0] exp, input string name);
    logic [7:0] act;
    act = {vdd_pg, vdda_pg, vref_pg, pwr_ack, busy, state};
    recordCheck(act === exp, name, act, exp);
  endtask

  task automatic expectFor(input int n, input logic [7:0] exp, input string name);
    for (int k = 0; k < n; k++) begin
      tick();
      checkOutput(exp, $sformatf("%s#%0d", name, k));
    end
  endtask

  task automatic doReset(input string name);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput(ev(3'b000, 3'd0), name);
  endtask

  // Invariant checker: rails must always form a legal prefix, and outside
  // of reset edges at most one rail may change per clock.
  always @(posedge clk) rst_at_edge <= rst_n;

  always @(negedge clk) begin
    if (inv_armed) begin
      recordCheck(!((vdda_pg && !vdd_pg) || (vref_pg && !vdda_pg)), "rail_order",
                  {5'b0, vdd_pg, vdda_pg, vref_pg}, 8'b0);
      if (rst_at_edge) begin
        recordCheck($countones({vdd_pg, vdda_pg, vref_pg} ^ prev_rails) <= 1,
                    "one_toggle", {5'b0, vdd_pg, vdda_pg, vref_pg}, {5'b0, prev_rails});
      end
    end
    prev_rails <= {vdd_pg, vdda_pg, vref_pg};
  end

  initial begin
    logic r_req, r_force, r_hold, r_step, r_rst;

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    setDly(8'd0, 8'd0, 8'd0);

    // Basic power-up with dly=2, then power-down with dly=1 during which a
    // new request arrives; the down sequence must finish before re-power-up.
    vecs.push_back(mkv(0,0,0,0,0, 8'd2, 3'b000, 3'd0));
    vecs.push_back(mkv(1,1,0,0,0, 8'd2, 3'b100, 3'd1));
    vecs.push_back(mkv(1,1,0,0,0, 8'd2, 3'b100, 3'd1));
    vecs.push_back(mkv(1,1,0,0,0, 8'd2, 3'b100, 3'd1));
    vecs.push_back(mkv(1,1,0,0,0, 8'd2, 3'b110, 3'd2));
    vecs.push_back(mkv(1,1,0,0,0, 8'd2, 3'b110, 3'd2));
    vecs.push_back(mkv(1,1,0,0,0, 8'd2, 3'b110, 3'd2));
    vecs.push_back(mkv(1,1,0,0,0, 8'd2, 3'b111, 3'd3));
    vecs.push_back(mkv(1,1,0,0,0, 8'd2, 3'b111, 3'd3));
    vecs.push_back(mkv(1,1,0,0,0, 8'd2, 3'b111, 3'd3));
    vecs.push_back(mkv(1,1,0,0,0, 8'd2, 3'b111, 3'd4));
    vecs.push_back(mkv(1,1,0,0,0, 8'd1, 3'b111, 3'd4));
    vecs.push_back(mkv(1,0,0,0,0, 8'd1, 3'b110, 3'd5));
    vecs.push_back(mkv(1,0,0,0,0, 8'd1, 3'b110, 3'd5));
    vecs.push_back(mkv(1,1,0,0,0, 8'd1, 3'b100, 3'd6));
    vecs.push_back(mkv(1,1,0,0,0, 8'd1, 3'b100, 3'd6));
    vecs.push_back(mkv(1,1,0,0,0, 8'd1, 3'b000, 3'd7));
    vecs.push_back(mkv(1,1,0,0,0, 8'd1, 3'b000, 3'd7));
    vecs.push_back(mkv(1,1,0,0,0, 8'd1, 3'b000, 3'd0));
    vecs.push_back(mkv(1,1,0,0,0, 8'd1, 3'b100, 3'd1));
    vecs.push_back(mkv(1,1,0,0,0, 8'd1, 3'b100, 3'd1));
    vecs.push_back(mkv(1,1,0,0,0, 8'd1, 3'b110, 3'd2));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].req, vecs[i].force_off, vecs[i].hold, vecs[i].step);
      setDly(vecs[i].dly, vecs[i].dly, vecs[i].dly);
      tick();
      checkOutput(ev(vecs[i].rails, vecs[i].st), $sformatf("table[%0d]", i));
      if (i == 0) inv_armed = 1'b1;
    end

    // Abort two cycles into UP_VDDA: VDDA dwell completes, then unwinds.
    $display("[TB] abort during power-up");
    doReset("abort reset");
    setDly(8'd1, 8'd5, 8'd1);
    applyStimulus(1, 1, 0, 0, 0);
    expectFor(2, ev(3'b100, 3'd1), "abort up_vdd");
    expectFor(2, ev(3'b110, 3'd2), "abort up_vdda");
    applyStimulus(1, 0, 0, 0, 0);
    expectFor(4, ev(3'b110, 3'd2), "abort up_vdda_finish");
    expectFor(6, ev(3'b100, 3'd6), "abort dn_vdda");
    expectFor(2, ev(3'b000, 3'd7), "abort dn_vdd");
    expectFor(1, ev(3'b000, 3'd0), "abort off");

    // Hold freezes the counter: remaining dwell resumes after release.
    $display("[TB] hold freezes dwell");
    doReset("freeze reset");
    setDly(8'd4, 8'd0, 8'd0);
    applyStimulus(1, 1, 0, 0, 0);
    expectFor(2, ev(3'b100, 3'd1), "freeze pre");
    applyStimulus(1, 1, 0, 1, 0);
    expectFor(10, ev(3'b100, 3'd1), "freeze held");
    applyStimulus(1, 1, 0, 0, 0);
    expectFor(3, ev(3'b100, 3'd1), "freeze resume");
    expectFor(1, ev(3'b110, 3'd2), "freeze advance");

    // Hold and single-step with long dwells.
    $display("[TB] hold and step");
    doReset("step reset");
    setDly(8'd200, 8'd200, 8'd200);
    applyStimulus(1, 1, 0, 0, 0);
    expectFor(1, ev(3'b100, 3'd1), "step up_vdd");
    applyStimulus(1, 1, 0, 0, 1);
    expectFor(1, ev(3'b100, 3'd1), "step unheld_ignored");
    applyStimulus(1, 1, 0, 1, 0);
    expectFor(50, ev(3'b100, 3'd1), "step held");
    applyStimulus(1, 1, 0, 1, 1);
    expectFor(1, ev(3'b110, 3'd2), "step to_vdda");
    applyStimulus(1, 1, 0, 1, 0);
    expectFor(1, ev(3'b110, 3'd2), "step gap1");
    applyStimulus(1, 1, 0, 1, 1);
    expectFor(1, ev(3'b111, 3'd3), "step to_vref");
    applyStimulus(1, 1, 0, 1, 0);
    expectFor(1, ev(3'b111, 3'd3), "step gap2");
    applyStimulus(1, 1, 0, 1, 1);
    expectFor(1, ev(3'b111, 3'd4), "step to_on");
    applyStimulus(1, 1, 0, 1, 0);
    expectFor(1, ev(3'b111, 3'd4), "step gap3");
    setDly(8'd0, 8'd0, 8'd0);
    applyStimulus(1, 0, 0, 1, 0);
    expectFor(3, ev(3'b111, 3'd4), "step held_on");
    applyStimulus(1, 0, 0, 1, 1);
    expectFor(1, ev(3'b110, 3'd5), "step to_dn");
    expectFor(4, ev(3'b110, 3'd5), "step held_high");
    applyStimulus(1, 0, 0, 0, 0);
    expectFor(1, ev(3'b100, 3'd6), "step rel_vdda");
    expectFor(1, ev(3'b000, 3'd7), "step rel_vdd");
    expectFor(1, ev(3'b000, 3'd0), "step rel_off");

    // Forced off while requested, re-power-up, reset mid-sequence, and an
    // abort straight out of UP_VDD.
    $display("[TB] force-off and reset");
    doReset("force reset");
    setDly(8'd0, 8'd0, 8'd0);
    applyStimulus(1, 1, 0, 0, 0);
    expectFor(1, ev(3'b100, 3'd1), "force up_vdd");
    expectFor(1, ev(3'b110, 3'd2), "force up_vdda");
    expectFor(1, ev(3'b111, 3'd3), "force up_vref");
    expectFor(1, ev(3'b111, 3'd4), "force on");
    applyStimulus(1, 1, 1, 0, 0);
    expectFor(1, ev(3'b110, 3'd5), "force dn_vref");
    expectFor(1, ev(3'b100, 3'd6), "force dn_vdda");
    expectFor(1, ev(3'b000, 3'd7), "force dn_vdd");
    expectFor(2, ev(3'b000, 3'd0), "force off");
    setDly(8'd1, 8'd1, 8'd1);
    applyStimulus(1, 1, 0, 0, 0);
    expectFor(2, ev(3'b100, 3'd1), "rst up_vdd");
    expectFor(2, ev(3'b110, 3'd2), "rst up_vdda");
    expectFor(1, ev(3'b111, 3'd3), "rst up_vref");
    applyStimulus(0, 1, 0, 0, 0);
    expectFor(1, ev(3'b000, 3'd0), "rst mid");
    applyStimulus(1, 1, 0, 0, 0);
    expectFor(1, ev(3'b100, 3'd1), "rst restart");
    applyStimulus(1, 0, 0, 0, 0);
    expectFor(1, ev(3'b100, 3'd1), "abort_vdd dwell");
    expectFor(2, ev(3'b000, 3'd7), "abort_vdd dn_vdd");
    expectFor(1, ev(3'b000, 3'd0), "abort_vdd off");

    // Randomized run; only the invariant checker judges these cycles.
    $display("[TB] randomized invariant run");
    r_req = 1'b0; r_force = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) r_req = ~r_req;
      if ($urandom_range(0, 29) == 0) r_force = ~r_force;
      r_hold = ($urandom_range(0, 3) == 0);
      r_step = $urandom_range(0, 1) == 1;
      r_rst  = ($urandom_range(0, 99) != 0);
      setDly(8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)));
      applyStimulus(r_rst, r_req, r_force, r_hold, r_step);
      tick();
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
